// File: rtl/gray_position_decoder.sv
// gray_position_decoder: synchronizes a gray-coded position, decodes it to binary
// and accumulates +/-1 steps into a signed position with illegal-jump counting.
module gray_position_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] G_in,
    input  logic             en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] B,
    output logic [15:0]      pos,
    output logic             step_valid,
    output logic             dir,
    output logic             err,
    output logic [7:0]       err_cnt
);
    typedef enum logic {INIT, TRACK} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] g_s, b_s, d, b_d;
    logic [1:0]       fill, fill_d;
    logic [15:0]      pos_d;
    logic             dir_d, sv_d, err_d;
    logic [7:0]       cnt_d;

    assign g_s = sync_q[SYNC_STAGES-1];
    assign d   = b_s - B;

    always_comb begin
        b_s = g_s;
        for (int i = WIDTH - 2; i >= 0; i--) b_s[i] = b_s[i+1] ^ g_s[i];
    end

    always_comb begin
        state_d = state;
        fill_d  = fill;
        b_d     = B;
        pos_d   = pos;
        dir_d   = dir;
        sv_d    = 1'b0;
        err_d   = 1'b0;
        if (state == INIT) begin
            if (!en) begin
                fill_d = '0;
            end else if (fill == 2'(SYNC_STAGES)) begin
                fill_d  = '0;
                b_d     = b_s;
                state_d = TRACK;
            end else begin
                fill_d = fill + 2'd1;
            end
        end else if (!en) begin
            state_d = INIT;
        end else if (d == WIDTH'(1)) begin
            b_d   = b_s;
            pos_d = pos + 16'd1;
            dir_d = 1'b1;
            sv_d  = 1'b1;
        end else if (&d) begin
            b_d   = b_s;
            pos_d = pos - 16'd1;
            dir_d = 1'b0;
            sv_d  = 1'b1;
        end else if (d != '0) begin
            b_d   = b_s;
            err_d = 1'b1;
        end
        cnt_d = clr_err ? {7'd0, err_d} : err_cnt + 8'(err_d && err_cnt != 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            state      <= INIT;
            fill       <= '0;
            B          <= '0;
            pos        <= '0;
            dir        <= 1'b0;
            step_valid <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            sync_q[0] <= G_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state      <= state_d;
            fill       <= fill_d;
            B          <= b_d;
            pos        <= pos_d;
            dir        <= dir_d;
            step_valid <= sv_d;
            err        <= err_d;
            err_cnt    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_gray_position_decoder.sv
// tb_gray_position_decoder: directed scenarios plus randomized walks checked
// against a cycle-level reference model of the position tracker.
module tb_gray_position_decoder;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  G_in = '0;
    logic        en = 1'b0;
    logic        clr_err = 1'b0;
    logic [3:0]  B;
    logic [15:0] pos;
    logic        step_valid, dir, err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    int          m_sync [S];
    bit          m_trk;
    int          m_fill, m_B, m_cnt;
    logic [15:0] m_pos;
    bit          m_dir, m_sv, m_err;

    wire  [30:0] obs = {B, pos, step_valid, dir, err, err_cnt};
    logic [30:0] exp_v;
    assign exp_v = {4'(m_B), m_pos, m_sv, m_dir, m_err, 8'(m_cnt)};

    gray_position_decoder #(.WIDTH(4), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .G_in(G_in), .en(en), .clr_err(clr_err),
        .B(B), .pos(pos), .step_valid(step_valid), .dir(dir), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int g2b(int g);
        int b = 0;
        for (int i = 0; i < 4; i++) b ^= g >> i;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_sync[i] = 0;
        m_trk = 0; m_fill = 0; m_B = 0; m_cnt = 0;
        m_pos = '0; m_dir = 0; m_sv = 0; m_err = 0;
    endtask

    task automatic model_step();
        int bs, dd;
        bs = g2b(m_sync[S-1]);
        m_sv = 0;
        m_err = 0;
        if (!m_trk) begin
            if (!en) m_fill = 0;
            else if (m_fill == S) begin m_B = bs; m_trk = 1; m_fill = 0; end
            else m_fill++;
        end else if (!en) begin
            m_trk = 0;
        end else begin
            dd = (bs - m_B + 16) % 16;
            if (dd == 1) begin m_B = bs; m_pos = m_pos + 16'd1; m_dir = 1; m_sv = 1; end
            else if (dd == 15) begin m_B = bs; m_pos = m_pos - 16'd1; m_dir = 0; m_sv = 1; end
            else if (dd != 0) begin m_B = bs; m_err = 1; end
        end
        if (clr_err) m_cnt = m_err ? 1 : 0;
        else if (m_err && m_cnt < 255) m_cnt++;
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = int'(G_in);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
    endtask

    task automatic restart(input int g);
        rst_n = 1'b0;
        #1;
        model_reset();
        G_in = 4'(g); en = 1'b1; clr_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        G_in = 4'hA; en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
            G_in = ~G_in;
        end
    endtask

    task automatic test_startup();
        rst_n = 1'b0; G_in = 4'b0110; en = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL startup_model t=%0d got=%h exp=%h", t, obs, exp_v); end
            checks++;
            if ({step_valid, err} !== 2'b00) begin failures++; $display("FAIL startup_pulse t=%0d got=%b exp=00", t, {step_valid, err}); end
            if (t < 3) begin
                checks++;
                if (B !== 4'b0000) begin failures++; $display("FAIL startup_early_B t=%0d got=%b exp=0000", t, B); end
            end
            if (t == 3) begin
                checks++;
                if ({B, pos} !== {4'b0100, 16'd0}) begin failures++; $display("FAIL startup_load got=%b/%0d exp=0100/0", B, pos); end
            end
        end
    endtask

    task automatic test_up_walk();
        int seq [3] = '{1, 3, 2};
        int pulses = 0;
        restart(0);
        for (int k = 0; k < 3; k++) begin
            G_in = 4'(seq[k]);
            for (int t = 1; t <= 4; t++) begin
                tick();
                pulses += int'(step_valid);
                checks++;
                if (obs !== exp_v) begin failures++; $display("FAIL up_walk_model k=%0d t=%0d got=%h exp=%h", k, t, obs, exp_v); end
                checks++;
                if (step_valid !== (t == 3)) begin failures++; $display("FAIL up_walk_latency k=%0d t=%0d got=%b exp=%b", k, t, step_valid, t == 3); end
            end
        end
        checks++;
        if (pulses != 3 || {B, pos, dir} !== {4'b0011, 16'd3, 1'b1})
            begin failures++; $display("FAIL up_walk_final got=%0d/%b/%0d/%b exp=3/0011/3/1", pulses, B, pos, dir); end
    endtask

    task automatic test_wrap();
        restart(4'b1000);
        checks++;
        if (B !== 4'b1111) begin failures++; $display("FAIL wrap_start got=%b exp=1111", B); end
        G_in = 4'b0000;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL wrap_up_model t=%0d got=%h exp=%h", t, obs, exp_v); end
        end
        checks++;
        if ({B, pos, dir} !== {4'b0000, 16'd1, 1'b1}) begin failures++; $display("FAIL wrap_up got=%b/%0d/%b exp=0000/1/1", B, pos, dir); end
        G_in = 4'b1000;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 3) begin
                checks++;
                if (step_valid !== 1'b1) begin failures++; $display("FAIL wrap_down_pulse got=%b exp=1", step_valid); end
            end
        end
        checks++;
        if ({B, pos, dir} !== {4'b1111, 16'd0, 1'b0}) begin failures++; $display("FAIL wrap_down got=%b/%0d/%b exp=1111/0/0", B, pos, dir); end
    endtask

    task automatic test_illegal();
        restart(0);
        G_in = 4'b0100;
        repeat (3) tick();
        checks++;
        if ({err, step_valid, B, pos, err_cnt} !== {1'b1, 1'b0, 4'b0111, 16'd0, 8'd1})
            begin failures++; $display("FAIL illegal_jump got=%b/%b/%b/%0d/%0d exp=1/0/0111/0/1", err, step_valid, B, pos, err_cnt); end
        tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL illegal_one_pulse got=%b exp=0", err); end
        for (int t = 0; t < 310; t++) begin
            G_in = G_in ^ 4'b0100;
            tick();
        end
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL saturate_model got=%h exp=%h", obs, exp_v); end
        checks++;
        if (err_cnt !== 8'd255) begin failures++; $display("FAIL saturate got=%0d exp=255", err_cnt); end
        G_in = G_in ^ 4'b0100; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if ({err, err_cnt} !== {1'b1, 8'd1}) begin failures++; $display("FAIL clr_with_err got=%b/%0d exp=1/1", err, err_cnt); end
        repeat (4) tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL illegal_settle got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_disable();
        restart(0);
        G_in = 4'b0001;
        repeat (4) tick();
        en = 1'b0; G_in = 4'b0011;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++;
            if ({step_valid, err, B, pos} !== {2'b00, 4'b0001, 16'd1})
                begin failures++; $display("FAIL disable_hold t=%0d got=%b%b/%b/%0d exp=00/0001/1", t, step_valid, err, B, pos); end
        end
        en = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL disable_reload_model t=%0d got=%h exp=%h", t, obs, exp_v); end
            checks++;
            if (B !== (t < 3 ? 4'b0001 : 4'b0010) || step_valid !== 1'b0)
                begin failures++; $display("FAIL disable_reload t=%0d got=%b/%b exp=%b/0", t, B, step_valid, t < 3 ? 4'b0001 : 4'b0010); end
        end
    endtask

    task automatic test_async_reset();
        restart(0);
        G_in = 4'b0001;
        repeat (4) tick();
        G_in = 4'b0011;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", obs); end
        tick();
        #2;
        rst_n = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL post_reset_model t=%0d got=%h exp=%h", t, obs, exp_v); end
            checks++;
            if (B !== (t < 3 ? 4'b0000 : 4'b0010) || step_valid !== 1'b0)
                begin failures++; $display("FAIL post_reset_init t=%0d got=%b/%b exp=%b/0", t, B, step_valid, t < 3 ? 4'b0000 : 4'b0010); end
        end
    endtask

    task automatic test_random();
        int cb = $urandom_range(0, 15);
        int r;
        restart(cb ^ (cb >> 1));
        for (int t = 0; t < 3000; t++) begin
            r = $urandom_range(0, 9);
            if (r == 6) cb = (cb + 1) % 16;
            else if (r == 7) cb = (cb + 15) % 16;
            else if (r == 8) cb = $urandom_range(0, 15);
            G_in = 4'(cb ^ (cb >> 1));
            if ($urandom_range(0, 39) == 0) en = ~en;
            clr_err = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL random_model t=%0d got=%h exp=%h", t, obs, exp_v); end
            checks++;
            if (step_valid && err) begin failures++; $display("FAIL random_exclusive t=%0d got=11 exp=not both", t); end
        end
        clr_err = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_up_walk();
        test_wrap();
        test_illegal();
        test_disable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
